mul_input_arbiter: RTL and testbench

MUL_INPUT_ARBITER -- requirements
Module: mul_input_arbiter

---
 rtl/mul_input_arbiter.sv | 94 +++++++++
 tb/tb_mul_input_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mul_input_arbiter.sv
// mul_input_arbiter: CONF-priority 2:1 arbiter feeding the multiplier stream; MUL_ARB_FAIRNESS_EN bounds CONF bursts while DATA waits.
module mul_input_arbiter #(
    parameter int TYPE_WIDTH     = 2,
    parameter int SEQ_WIDTH      = 8,
    parameter int SOURCE_WIDTH   = 8,
    parameter int PAYLOAD_WIDTH  = 16,
    parameter int MAX_CONF_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hlt,
    input  logic                     dat_valid,
    output logic                     dat_ready,
    input  logic [TYPE_WIDTH-1:0]    dat_type,
    input  logic [SEQ_WIDTH-1:0]     dat_seqNum,
    input  logic [SOURCE_WIDTH-1:0]  dat_sourceAddress,
    input  logic [PAYLOAD_WIDTH-1:0] dat_data,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [TYPE_WIDTH-1:0]    cfg_type,
    input  logic [SEQ_WIDTH-1:0]     cfg_seqNum,
    input  logic [SOURCE_WIDTH-1:0]  cfg_sourceAddress,
    input  logic [PAYLOAD_WIDTH-1:0] cfg_data,
    output logic                     SNC_MUL_valid,
    output logic [TYPE_WIDTH-1:0]    SNC_MUL_type,
    output logic [SEQ_WIDTH-1:0]     SNC_MUL_seqNum,
    output logic [SOURCE_WIDTH-1:0]  SNC_MUL_sourceAddress,
    output logic [PAYLOAD_WIDTH-1:0] SNC_MUL_data,
    output logic [1:0]               owner
);
    localparam int CNT_W = $clog2(MAX_CONF_BURST + 1);
    typedef enum logic [1:0] {IDLE = 2'b00, DATA = 2'b01, CONF = 2'b10} state_t;
    state_t                   state_q, state_d;
    logic                     valid_q, valid_d;
    logic [TYPE_WIDTH-1:0]    type_q, type_d;
    logic [SEQ_WIDTH-1:0]     seq_q, seq_d;
    logic [SOURCE_WIDTH-1:0]  src_q, src_d;
    logic [PAYLOAD_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]         conf_cnt;
    logic                     force_data, grant_cfg, grant_dat;
`ifdef MUL_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = (!hlt && (grant_dat || !dat_valid)) ? '0 :
                (grant_cfg && cnt_q != CNT_W'(MAX_CONF_BURST)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
    assign conf_cnt = cnt_q;
`else
    localparam bit FAIR = 1'b0;
    assign conf_cnt = '0;
`endif
    // readies are gated by rst so they drop immediately when reset asserts
    assign force_data = FAIR && dat_valid && (conf_cnt == CNT_W'(MAX_CONF_BURST));
    assign grant_cfg  = rst && !hlt && cfg_valid && !force_data;
    assign grant_dat  = rst && !hlt && dat_valid && !grant_cfg;
    assign cfg_ready  = grant_cfg;
    assign dat_ready  = grant_dat;
    always_comb begin
        valid_d = hlt ? valid_q : (grant_cfg || grant_dat);
        type_d  = grant_cfg ? cfg_type          : grant_dat ? dat_type          : type_q;
        seq_d   = grant_cfg ? cfg_seqNum        : grant_dat ? dat_seqNum        : seq_q;
        src_d   = grant_cfg ? cfg_sourceAddress : grant_dat ? dat_sourceAddress : src_q;
        data_d  = grant_cfg ? cfg_data          : grant_dat ? dat_data          : data_q;
        state_d = hlt ? state_q : grant_cfg ? CONF : grant_dat ? DATA : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            type_q  <= '0;
            seq_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            type_q  <= type_d;
            seq_q   <= seq_d;
            src_q   <= src_d;
            data_q  <= data_d;
        end
    end
    assign SNC_MUL_valid         = valid_q;
    assign SNC_MUL_type          = type_q;
    assign SNC_MUL_seqNum        = seq_q;
    assign SNC_MUL_sourceAddress = src_q;
    assign SNC_MUL_data          = data_q;
    assign owner                 = state_q;
endmodule

// File: tb/tb_mul_input_arbiter.sv
// tb_mul_input_arbiter: directed vector table plus burst, fairness and reset sequences for mul_input_arbiter.
module tb_mul_input_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hlt = 1'b0;
    logic        dat_valid = 1'b0, cfg_valid = 1'b0;
    logic        dat_ready, cfg_ready;
    logic [1:0]  dat_type = 2'd1, cfg_type = 2'd2;
    logic [7:0]  dat_seqNum = '0, cfg_seqNum = '0, dat_sourceAddress = '0, cfg_sourceAddress = '0;
    logic [15:0] dat_data = '0, cfg_data = '0;
    logic        SNC_MUL_valid;
    logic [1:0]  SNC_MUL_type, owner;
    logic [7:0]  SNC_MUL_seqNum, SNC_MUL_sourceAddress;
    logic [15:0] SNC_MUL_data;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    mul_input_arbiter dut (
        .clk(clk), .rst(rst), .hlt(hlt),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_type(dat_type), .dat_seqNum(dat_seqNum),
        .dat_sourceAddress(dat_sourceAddress), .dat_data(dat_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_type(cfg_type), .cfg_seqNum(cfg_seqNum),
        .cfg_sourceAddress(cfg_sourceAddress), .cfg_data(cfg_data),
        .SNC_MUL_valid(SNC_MUL_valid), .SNC_MUL_type(SNC_MUL_type), .SNC_MUL_seqNum(SNC_MUL_seqNum),
        .SNC_MUL_sourceAddress(SNC_MUL_sourceAddress), .SNC_MUL_data(SNC_MUL_data), .owner(owner)
    );

    typedef struct {
        logic hlt, dv, cv;
        logic [7:0] dsrc; logic [15:0] ddata;
        logic [7:0] csrc; logic [15:0] cdata;
        logic [1:0] e_rdy; logic e_v; logic [1:0] e_type;
        logic [7:0] e_seq, e_src; logic [15:0] e_data; logic [1:0] e_own;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic dv, input logic cv, input logic [7:0] ds, input logic [15:0] dd,
                         input logic [7:0] cs, input logic [15:0] cd);
        hlt = h; dat_valid = dv; cfg_valid = cv;
        dat_sourceAddress = ds; dat_data = dd; dat_seqNum = ds + 8'h40;
        cfg_sourceAddress = cs; cfg_data = cd; cfg_seqNum = cs + 8'h80;
    endtask

    initial begin
        //          hlt dv cv dsrc ddata     csrc cdata     rdy   v  type  seq    src   data      own
        vecs[0]  = '{0, 1, 0, 8'd3, 16'h0010, 8'd0, 16'h0000, 2'b01, 1, 2'd1, 8'h43, 8'd3, 16'h0010, 2'b01};
        vecs[1]  = '{0, 1, 1, 8'd4, 16'h0020, 8'd5, 16'hBEEF, 2'b10, 1, 2'd2, 8'h85, 8'd5, 16'hBEEF, 2'b10};
        vecs[2]  = '{0, 1, 0, 8'd4, 16'h0020, 8'd0, 16'h0000, 2'b01, 1, 2'd1, 8'h44, 8'd4, 16'h0020, 2'b01};
        vecs[3]  = '{0, 0, 0, 8'd0, 16'h0000, 8'd0, 16'h0000, 2'b00, 0, 2'd1, 8'h44, 8'd4, 16'h0020, 2'b00};
        vecs[4]  = '{0, 0, 0, 8'd0, 16'h0000, 8'd0, 16'h0000, 2'b00, 0, 2'd1, 8'h44, 8'd4, 16'h0020, 2'b00};
        vecs[5]  = '{0, 0, 1, 8'd0, 16'h0000, 8'd6, 16'h1234, 2'b10, 1, 2'd2, 8'h86, 8'd6, 16'h1234, 2'b10};
        vecs[6]  = '{1, 1, 1, 8'd7, 16'h7777, 8'd8, 16'h8888, 2'b00, 1, 2'd2, 8'h86, 8'd6, 16'h1234, 2'b10};
        vecs[7]  = '{1, 1, 1, 8'd7, 16'h7777, 8'd8, 16'h8888, 2'b00, 1, 2'd2, 8'h86, 8'd6, 16'h1234, 2'b10};
        vecs[8]  = '{1, 1, 1, 8'd7, 16'h7777, 8'd8, 16'h8888, 2'b00, 1, 2'd2, 8'h86, 8'd6, 16'h1234, 2'b10};
        vecs[9]  = '{0, 1, 1, 8'd7, 16'h7777, 8'd8, 16'h8888, 2'b10, 1, 2'd2, 8'h88, 8'd8, 16'h8888, 2'b10};
        vecs[10] = '{0, 1, 0, 8'd7, 16'h7777, 8'd0, 16'h0000, 2'b01, 1, 2'd1, 8'h47, 8'd7, 16'h7777, 2'b01};
        vecs[11] = '{1, 0, 0, 8'd0, 16'h0000, 8'd0, 16'h0000, 2'b00, 1, 2'd1, 8'h47, 8'd7, 16'h7777, 2'b01};
        vecs[12] = '{0, 0, 0, 8'd0, 16'h0000, 8'd0, 16'h0000, 2'b00, 0, 2'd1, 8'h47, 8'd7, 16'h7777, 2'b00};

        // reset held with both requesters valid: nothing may be granted
        drive(0, 1, 1, 8'd1, 16'h1111, 8'd2, 16'h2222);
        #12;
        chk("rst_rdy", 0, {cfg_ready, dat_ready}, 2'b00);
        chk("rst_valid", 0, SNC_MUL_valid, 1'b0);
        chk("rst_fields", 0, {SNC_MUL_type, SNC_MUL_seqNum, SNC_MUL_sourceAddress, SNC_MUL_data}, 34'd0);
        chk("rst_owner", 0, owner, 2'b00);
        drive(0, 0, 0, 8'd0, 16'h0, 8'd0, 16'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].hlt, vecs[i].dv, vecs[i].cv, vecs[i].dsrc, vecs[i].ddata, vecs[i].csrc, vecs[i].cdata);
            #1;
            chk("ready", i, {cfg_ready, dat_ready}, vecs[i].e_rdy);
            @(posedge clk);
            #1;
            chk("valid", i, SNC_MUL_valid, vecs[i].e_v);
            chk("fields", i, {SNC_MUL_type, SNC_MUL_seqNum, SNC_MUL_sourceAddress, SNC_MUL_data},
                {vecs[i].e_type, vecs[i].e_seq, vecs[i].e_src, vecs[i].e_data});
            chk("owner", i, owner, vecs[i].e_own);
        end

        // both requesters valid for 10 cycles starting from a cleared streak
        for (int i = 0; i < 10; i++) begin
            logic [1:0] exp_rdy;
`ifdef MUL_ARB_FAIRNESS_EN
            exp_rdy = (i % 5 == 4) ? 2'b01 : 2'b10;
`else
            exp_rdy = 2'b10;
`endif
            @(negedge clk);
            drive(0, 1, 1, 8'd9, 16'h0999, 8'd10, 16'h0AAA);
            #1;
            chk("burst_rdy", i, {cfg_ready, dat_ready}, exp_rdy);
            @(posedge clk);
            #1;
            chk("burst_src", i, SNC_MUL_sourceAddress, exp_rdy[1] ? 8'd10 : 8'd9);
        end

        // asynchronous reset in the middle of a CONF burst
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 0, SNC_MUL_valid, 1'b0);
        chk("mid_rst_rdy", 0, {cfg_ready, dat_ready}, 2'b00);
        chk("mid_rst_owner", 0, owner, 2'b00);
        chk("mid_rst_fields", 0, {SNC_MUL_type, SNC_MUL_seqNum, SNC_MUL_sourceAddress, SNC_MUL_data}, 34'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_cnt", 0, dut.conf_cnt, 0);
        chk("post_rst_rdy", 0, {cfg_ready, dat_ready}, 2'b10);
        @(posedge clk);
        #1;
        chk("post_rst_valid", 0, SNC_MUL_valid, 1'b1);
        chk("post_rst_src", 0, SNC_MUL_sourceAddress, 8'd10);
        chk("post_rst_owner", 0, owner, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
